// File: rtl/ro_pkg.sv
// Shared constants and FSM state type for the ring-oscillator select sweep.
package ro_pkg;

    localparam int unsigned SEL_W    = 3;
    localparam int unsigned NUM_TAPS = 8;

    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(NUM_TAPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT,
        ST_DONE
    } ro_sweep_state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer plus a third flop; flags a rising edge of async_in.
module ro_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/ro_select_sweep.sv
// Steps the fine-delay tap select 0..7, counting ring-oscillator edges per tap.
// Optional best-tap tracker is built when RO_SWEEP_BEST_EN is defined.
module ro_select_sweep
    import ro_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 4096,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             osc_in,
`ifdef RO_SWEEP_BEST_EN
    input  logic [CNT_W-1:0] target,
    output logic [SEL_W-1:0] best_sel,
`endif
    output logic [SEL_W-1:0] select,
    output logic             busy,
    output logic             result_valid,
    output logic [SEL_W-1:0] result_sel,
    output logic [CNT_W-1:0] result_count,
    output logic             done
);

    localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    ro_sweep_state_t  state;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt_c;
    logic             rise;

    ro_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (osc_in),
        .rise     (rise)
    );

    // Saturating increment so a fast oscillator pins at full scale instead of wrapping.
    always_comb begin
        edge_nxt_c = edge_cnt;
        if (rise && (edge_cnt != {CNT_W{1'b1}}))
            edge_nxt_c = edge_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tmr          <= '0;
            edge_cnt     <= '0;
            select       <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_sel   <= '0;
            result_count <= '0;
            done         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SETTLE;
                        select <= '0;
                        tmr    <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                        state    <= ST_MEASURE;
                        tmr      <= '0;
                        edge_cnt <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_MEASURE: begin
                    edge_cnt <= edge_nxt_c;
                    if (tmr == TMR_W'(WINDOW_CYCLES - 1)) begin
                        state        <= ST_REPORT;
                        result_valid <= 1'b1;
                        result_sel   <= select;
                        result_count <= edge_nxt_c;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (select == LAST_TAP) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state  <= ST_SETTLE;
                        select <= select + SEL_W'(1);
                        tmr    <= '0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RO_SWEEP_BEST_EN
    logic [CNT_W-1:0] best_err;
    logic [SEL_W-1:0] best_tap;
    logic [CNT_W-1:0] err_c;
    logic [SEL_W-1:0] best_tap_nxt_c;

    // Strict less-than keeps the earlier (lower) tap on ties.
    always_comb begin
        err_c          = (result_count >= target) ? (result_count - target) : (target - result_count);
        best_tap_nxt_c = best_tap;
        if (err_c < best_err)
            best_tap_nxt_c = result_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_err <= '1;
            best_tap <= '0;
            best_sel <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                best_err <= '1;
                best_tap <= '0;
            end else if (state == ST_REPORT) begin
                if (err_c < best_err) begin
                    best_err <= err_c;
                    best_tap <= result_sel;
                end
                if (result_sel == LAST_TAP)
                    best_sel <= best_tap_nxt_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ro_select_sweep.sv
// Scoreboard bench for ro_select_sweep: stimulus queues expected results, monitors pop and compare.
module tb_ro_select_sweep;
    import ro_pkg::*;

    localparam int unsigned W       = 100;
    localparam int unsigned S       = 4;
    localparam int unsigned TAP_CYC = S + W + 1;

    typedef struct {
        int sel;
        int count;
        int tol;
    } exp_res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic        osc_a = 1'b0;
    logic        osc_b = 1'b0;
    logic [2:0]  select_a, rsel_a, select_b, rsel_b;
    logic        busy_a, rv_a, done_a, busy_b, rv_b, done_b;
    logic [15:0] rcnt_a;
    logic [3:0]  rcnt_b;
`ifdef RO_SWEEP_BEST_EN
    logic [15:0] target_a;
    logic [3:0]  target_b;
    logic [2:0]  best_a, best_b;
`endif

    ro_select_sweep #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .osc_in(osc_a),
`ifdef RO_SWEEP_BEST_EN
        .target(target_a), .best_sel(best_a),
`endif
        .select(select_a), .busy(busy_a), .result_valid(rv_a),
        .result_sel(rsel_a), .result_count(rcnt_a), .done(done_a)
    );

    ro_select_sweep #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .osc_in(osc_b),
`ifdef RO_SWEEP_BEST_EN
        .target(target_b), .best_sel(best_b),
`endif
        .select(select_b), .busy(busy_b), .result_valid(rv_b),
        .result_sel(rsel_b), .result_count(rcnt_b), .done(done_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_start = 0;
    bit tapdep = 1'b0;
    exp_res_t qa[$];
    exp_res_t qb[$];
    int qd_lat[$];
    int qd_best[$];
    int td_cnt[8] = '{25, 16, 12, 10, 8, 7, 6, 5};

    function automatic void check(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator A: period 10, or 4+2*select; phase restarts when select changes.
    int ph = 0;
    int per;
    logic [2:0] last_sel = 3'd0;
    always @(negedge clk) begin
        per = tapdep ? (4 + 2 * int'(select_a)) : 10;
        if (select_a != last_sel || ph >= per - 1) ph = 0;
        else ph = ph + 1;
        last_sel = select_a;
        osc_a = (ph < per / 2);
    end

    // Oscillator B: free-running period 4.
    int phb = 0;
    always @(negedge clk) begin
        phb = (phb + 1) % 4;
        osc_b = (phb < 2);
    end

    always @(negedge clk) begin : mon_a
        exp_res_t e;
        int lat;
        if (rst_n) begin
            if (rv_a) begin
                if (qa.size() == 0) begin
                    check("unexpected_result_a", int'(rsel_a), -1, -1);
                end else begin
                    e = qa.pop_front();
                    check("result_sel_a", int'(rsel_a), e.sel, e.sel);
                    check("result_count_a", int'(rcnt_a), e.count - e.tol, e.count + e.tol);
                end
            end
            if (done_a) begin
                if (qd_lat.size() == 0) begin
                    check("unexpected_done_a", 1, 0, 0);
                end else begin
                    lat = qd_lat.pop_front();
                    check("done_latency_a", cyc - t_start + 1, lat, lat);
                    check("busy_in_done_a", int'(busy_a), 0, 0);
                    check("results_before_done_a", qa.size(), 0, 0);
`ifdef RO_SWEEP_BEST_EN
                    lat = qd_best.pop_front();
                    check("best_sel_a", int'(best_a), lat, lat);
`else
                    void'(qd_best.pop_front());
`endif
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_res_t e;
        if (rst_n && rv_b) begin
            if (qb.size() == 0) begin
                check("unexpected_result_b", int'(rsel_b), -1, -1);
            end else begin
                e = qb.pop_front();
                check("result_sel_b", int'(rsel_b), e.sel, e.sel);
                check("result_count_b_sat", int'(rcnt_b), e.count, e.count);
            end
        end
    end

    task automatic push_sweep(input bit td, input int best);
        exp_res_t e;
        for (int i = 0; i < 8; i++) begin
            e.sel   = i;
            e.count = td ? td_cnt[i] : 10;
            e.tol   = td ? 1 : 0;
            qa.push_back(e);
        end
        qd_lat.push_back(8 * TAP_CYC + 1);
        qd_best.push_back(best);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        t_start = cyc;
        check("busy_after_start_a", int'(busy_a), 1, 1);
        check("select_at_start_a", int'(select_a), 0, 0);
    endtask

    task automatic wait_done_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done_a) ok = 1'b1;
        end
        if (!ok) check("timeout_done_a", 0, 1, 1);
    endtask

    initial begin
        bit ok;
        exp_res_t e;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
`ifdef RO_SWEEP_BEST_EN
        target_a = 16'd11;
        target_b = 4'd0;
`endif
        repeat (3) @(negedge clk);
        check("rst_select", int'(select_a), 0, 0);
        check("rst_busy", int'(busy_a), 0, 0);
        check("rst_result_valid", int'(rv_a), 0, 0);
        check("rst_result_sel", int'(rsel_a), 0, 0);
        check("rst_result_count", int'(rcnt_a), 0, 0);
        check("rst_done", int'(done_a), 0, 0);
        rst_n = 1'b1;

        // Constant period 10; start re-pulsed while busy and in the DONE cycle.
        push_sweep(1'b0, 0);
        pulse_start_a();
        repeat (300) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        wait_done_a(ok);
        if (ok) begin
            start_a = 1'b1;
            @(negedge clk) start_a = 1'b0;
        end
        repeat (150) @(negedge clk);
        check("idle_after_sweep_busy", int'(busy_a), 0, 0);
        check("idle_select_hold", int'(select_a), 7, 7);

        // Tap-dependent oscillator period.
        tapdep = 1'b1;
        push_sweep(1'b1, 2);
        pulse_start_a();
        wait_done_a(ok);
        repeat (5) @(negedge clk);

        // Reset during tap 3 MEASURE aborts the sweep.
        push_sweep(1'b1, 2);
        pulse_start_a();
        repeat (3 * TAP_CYC + S + 50) @(negedge clk);
        check("pre_abort_select", int'(select_a), 3, 3);
        #2 rst_n = 1'b0;
        #1;
        check("abort_select", int'(select_a), 0, 0);
        check("abort_busy", int'(busy_a), 0, 0);
        check("abort_result_valid", int'(rv_a), 0, 0);
        check("abort_result_sel", int'(rsel_a), 0, 0);
        check("abort_result_count", int'(rcnt_a), 0, 0);
        check("abort_done", int'(done_a), 0, 0);
        check("abort_results_left", qa.size(), 5, 5);
        qa.delete();
        qd_lat.delete();
        qd_best.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        push_sweep(1'b1, 2);
        pulse_start_a();
        wait_done_a(ok);

        // Narrow counter saturates at 15 (25 edges per window).
        for (int i = 0; i < 8; i++) begin
            e.sel = i;
            e.count = 15;
            e.tol = 0;
            qb.push_back(e);
        end
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done_b) ok = 1'b1;
        end
        check("done_b_seen", int'(ok), 1, 1);
        check("results_left_b", qb.size(), 0, 0);

        repeat (10) @(negedge clk);
        check("results_left_a", qa.size(), 0, 0);
        check("dones_left_a", qd_lat.size(), 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ro_select_sweep.md
# ro_select_sweep

Sweep controller directly upstream of the fine delay stage. It drives the stage's 3-bit `select` and visits all eight delay taps in turn. For each tap it waits a settling period, then counts rising edges of the ring-oscillator output over a fixed window of system-clock cycles. It reports one count per tap, letting software or a calibration engine characterise the per-tap delay and pick an operating point.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 4096: measurement window length in `clk` cycles, minimum 2.
- `SETTLE_CYCLES`, default 16: cycles discarded after each `select` change, minimum 1.
- `CNT_W`, default 16: edge-counter and result width.

Ports:
- `clk`  in  1  system clock, the single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `osc_in`  in  1  ring-oscillator output, asynchronous to `clk`.
- `target`  in  CNT_W  desired count; used only when RO_SWEEP_BEST_EN is defined.
- `select`  out  3  tap select driven into the fine delay stage.
- `busy`  out  1  high from the first SETTLE cycle through the last REPORT cycle.
- `result_valid`  out  1  one-cycle pulse, one per tap.
- `result_sel`  out  3  tap the current result belongs to.
- `result_count`  out  CNT_W  rising-edge count for `result_sel`.
- `done`  out  1  one-cycle pulse after the eighth result.
- `best_sel`  out  3  tap with count closest to `target`; present only with RO_SWEEP_BEST_EN.

## Operation
- `osc_in` passes through a two-flop synchronizer and a third flop; a rising edge is `s2 & ~s3`.
- Oscillator frequency must be below `clk`/2 for an exact count.
- FSM states: IDLE, SETTLE, MEASURE, REPORT, DONE.
  - IDLE with `start`=1 goes to SETTLE, with `select` cleared to 0 and the settle counter cleared.
  - SETTLE lasts SETTLE_CYCLES cycles, then goes to MEASURE. Edges seen during SETTLE are discarded.
  - MEASURE: the edge counter is cleared on entry. It counts edges for exactly WINDOW_CYCLES cycles, then the FSM goes to REPORT.
  - REPORT lasts one cycle, asserts `result_valid` and presents `result_sel`/`result_count`.
    - If `select`=7, the FSM goes to DONE.
    - Otherwise `select` increments and the FSM goes to SETTLE.
  - DONE lasts one cycle, pulses `done`, then returns to IDLE.
- `select` stays constant during SETTLE and MEASURE of a tap.
- In IDLE, `select` holds its last value, which is 7 after a completed sweep.
- The edge counter saturates at 2^CNT_W−1 and does not wrap.
- `start` outside IDLE is ignored and is not queued. `start` in the DONE cycle is also ignored.
- No backpressure: `result_*` are valid only during the `result_valid` cycle, and the consumer must capture them then.
- Asynchronous reset mid-sweep aborts the sweep: the FSM enters IDLE, no `done` is issued, and all outputs take their reset values.

## Timing
- Reset values:
  - `select`=0, `busy`=0, `result_valid`=0, `result_sel`=0, `result_count`=0, `done`=0.
  - `best_sel`=0; the internal best-error register resets to all-ones.
- `start` sampled high at cycle T: `busy`=1 and SETTLE begin at T+1.
- Per tap: SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles.
- Full sweep: 8·(SETTLE_CYCLES+WINDOW_CYCLES+1) cycles from T+1, then one DONE cycle.
- `busy` falls in the DONE cycle.
- Synchronizer latency is 3 cycles. Edges arriving in the last 3 MEASURE cycles may be counted against the next tap's SETTLE, which discards them.
- All outputs are registered.

## Configuration
- `RO_SWEEP_BEST_EN` defined:
  - At each REPORT, compute err = |result_count − target| at CNT_W bits, unsigned.
  - If err < best_err (strictly less), update best_err and `best_sel`; ties keep the earlier, lower tap.
  - best_err resets to all-ones at sweep start.
  - `best_sel` is updated in the DONE cycle and held until the next sweep's DONE.
- `RO_SWEEP_BEST_EN` undefined:
  - `target` and `best_sel` ports are absent.
  - No comparator logic is built.

## Structure
- Package `ro_pkg`:
  - `SEL_W`=3 and `NUM_TAPS`=8.
  - FSM state enum `ro_sweep_state_t`.
- Sub-module `ro_edge_sync`: two-flop synchronizer plus rising-edge detect; ports `clk`, `rst_n`, `async_in`, `rise`.
- Top level contains the FSM, settle/window counter, saturating edge counter and optional best-tap tracker.

## Test plan
- WINDOW_CYCLES=100, SETTLE_CYCLES=4; `osc_in` period 10 clk for all taps; pulse `start` → eight `result_valid` pulses, `result_sel` 0..7, each `result_count`=10. `done` arrives 8·105+1 cycles after `start`.
- Tap-dependent model, `osc_in` period = 4+2·`select` clk → counts 25, 16, 12, 10, 8, 7, 6, 5 (±1 for phase).
- CNT_W=4, period 4 clk, WINDOW_CYCLES=100 → every `result_count`=15, with no wrap.
- `start` re-pulsed while `busy`=1 and again in the DONE cycle → exactly one sweep of eight results.
- `rst_n` low during tap 3 MEASURE → all outputs 0 immediately, no `done`. A new `start` gives a complete sweep beginning at `select`=0.
- RO_SWEEP_BEST_EN, `target`=11, tap-dependent model → `best_sel`=2 (count 12 and count 10 tie at err 1; the lower tap wins).
